wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, 2, number of buffered mul/div results (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, 4, cycles a live buffered result may wait before forcing a pipeline stall (>=1).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports p_valid in 1, p_we in 1, p_dst in 5, p_val in 32, p_pc in 32: the pipeline writeback request.
REQ-006 SHALL have ports m_valid in 1, m_dst in 5, m_val in 32, m_pc in 32: the mul/div result request; m_ready out 1: buffer accepts.
REQ-007 SHALL have ports rf_we out 1, rf_dst out 5, rf_val out 32, rf_pc out 32: the single register-file write port.
REQ-008 SHALL have port pipe_stall  out  1  freeze the pipeline writeback stage this cycle.
REQ-009 SHALL have port pend_cnt  out  $clog2(DEPTH+1)  number of buffered entries, live or dead.

Function
REQ-010 SHALL hold mul/div results in a DEPTH-entry FIFO with head/tail pointers wrapping modulo DEPTH; each entry holds dst, val, pc, live.
REQ-011 SHALL drive m_ready = (pend_cnt < DEPTH) from registered count only; a full FIFO SHALL refuse a push even when it pops in the same cycle.
REQ-012 SHALL push on m_valid && m_ready; entry live = (m_dst != 0).
REQ-013 Pipeline request SHALL be eligible only when p_valid && p_we && p_dst != 0 && !pipe_stall.
REQ-014 Grant priority per cycle: FORCE state -> FIFO head; else eligible pipeline; else live FIFO head; else none.
REQ-015 A dead FIFO head SHALL be popped without a write whenever the head is not granted for writing, one entry per cycle.
REQ-016 A pipeline grant to dst d SHALL clear live on every entry present at the start of that cycle with dst d; an entry pushed in the same cycle SHALL NOT be killed.
REQ-017 rf_we/rf_dst/rf_val/rf_pc SHALL be registered: a grant in cycle N appears on the port in cycle N+1; rf_we=0 in cycle N+1 when no grant in N, other rf outputs then hold.
REQ-018 Starvation FSM states IDLE, WAIT, FORCE: IDLE->WAIT when head live and not granted; WAIT counts ungranted cycles, ->FORCE when count reaches STARVE_LIMIT; WAIT->IDLE when head is granted or becomes dead; FORCE->IDLE after one cycle, counter cleared.
REQ-019 pipe_stall SHALL be 1 exactly in the FORCE state (decoded from state register, one cycle).
REQ-020 Simultaneous push and pop on a non-full FIFO SHALL leave pend_cnt unchanged; pop on empty SHALL not occur.

Reset
REQ-021 On resetn low, asynchronously: FIFO emptied, pend_cnt=0, FSM=IDLE, counter=0, rf_we=0, rf_dst=0, rf_val=0, rf_pc=0, pipe_stall=0, m_ready=1 after release.
REQ-022 Reset during operation SHALL discard all buffered results without any register-file write.

Configuration
REQ-023 Macro WB_ARB_STARVE_EN: defined -> starvation FSM and pipe_stall per REQ-018/019; undefined -> FSM omitted, pipe_stall tied 0, FIFO head written only in cycles with no eligible pipeline request.

Verification
REQ-024 Reset, then m push dst=5 val=0x11 with pipeline idle -> rf_we=1 dst=5 val=0x11 two cycles after push cycle, pend_cnt back to 0.
REQ-025 Pipeline writes dst=3 every cycle, m push dst=7 -> rf shows dst=3 for STARVE_LIMIT cycles, then pipe_stall=1 one cycle and rf dst=7 next cycle (STARVE_EN on); STARVE_EN off -> dst=7 never written while pipeline busy.
REQ-026 Push dst=9 val=0xA, next cycle pipeline writes dst=9 val=0xB -> only 0xB written to r9, buffered entry popped dead, no second write.
REQ-027 Push DEPTH entries with pipeline busy -> m_ready=0, further m_valid ignored; pend_cnt=DEPTH; wrap-around order preserved on drain.
REQ-028 m push dst=0 -> rf_we never asserted for it, entry popped; resetn low with 2 entries pending -> pend_cnt=0, rf_we=0, no writes after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between the pipeline and a mul/div result FIFO.
// Rev 1.0. Optional starvation FSM: define WB_ARB_STARVE_EN.
`default_nettype none

module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       p_valid,
  input  logic                       p_we,
  input  logic [4:0]                 p_dst,
  input  logic [31:0]                p_val,
  input  logic [31:0]                p_pc,
  input  logic                       m_valid,
  input  logic [4:0]                 m_dst,
  input  logic [31:0]                m_val,
  input  logic [31:0]                m_pc,
  output logic                       m_ready,
  output logic                       rf_we,
  output logic [4:0]                 rf_dst,
  output logic [31:0]                rf_val,
  output logic [31:0]                rf_pc,
  output logic                       pipe_stall,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_chk
    $error("wb_port_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [4:0]       dst_q [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] cnt_q;

  logic        rf_we_q;
  logic [4:0]  rf_dst_q;
  logic [31:0] rf_val_q, rf_pc_q;

  logic push, pop, head_present, head_live, p_elig, p_gnt, h_gnt, force_act;

  assign m_ready      = (cnt_q < CNT_W'(DEPTH));
  assign pend_cnt     = cnt_q;
  assign push         = m_valid && m_ready;
  assign head_present = (cnt_q != '0);
  assign head_live    = head_present && live_q[head_q];
  assign p_elig       = p_valid && p_we && (p_dst != 5'd0) && !pipe_stall;
  // Dead heads drain one per cycle whenever the head is not being written.
  assign pop          = head_present && (h_gnt || !live_q[head_q]);

  always_comb begin
    p_gnt = 1'b0;
    h_gnt = 1'b0;
    if (force_act) begin
      h_gnt = head_live;
    end else if (p_elig) begin
      p_gnt = 1'b1;
    end else begin
      h_gnt = head_live;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SC_W-1:0] scnt_q, scnt_d;

  assign force_act  = (state_q == S_FORCE);
  assign pipe_stall = force_act;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      S_IDLE: begin
        if (head_live && !h_gnt) begin
          state_d = S_WAIT;
          scnt_d  = SC_W'(1);
        end
      end
      S_WAIT: begin
        if (!head_live || h_gnt) begin
          state_d = S_IDLE;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SC_W'(1);
          if (scnt_d >= SC_W'(STARVE_LIMIT)) begin
            state_d = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        state_d = S_IDLE;
        scnt_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        scnt_d  = '0;
      end
    endcase
  end
`else
  assign force_act  = 1'b0;
  assign pipe_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dst_q[tail_q] <= m_dst;
      val_q[tail_q] <= m_val;
      pc_q[tail_q]  <= m_pc;
    end
  end

  // The push write comes last so an entry arriving this cycle survives a same-dst kill.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (p_gnt && (dst_q[i] == p_dst)) live_q[i] <= 1'b0;
      end
      if (push) live_q[tail_q] <= (m_dst != 5'd0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_q  <= 1'b0;
      rf_dst_q <= '0;
      rf_val_q <= '0;
      rf_pc_q  <= '0;
    end else begin
      rf_we_q <= p_gnt || h_gnt;
      if (p_gnt) begin
        rf_dst_q <= p_dst;
        rf_val_q <= p_val;
        rf_pc_q  <= p_pc;
      end else if (h_gnt) begin
        rf_dst_q <= dst_q[head_q];
        rf_val_q <= val_q[head_q];
        rf_pc_q  <= pc_q[head_q];
      end
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_dst = rf_dst_q;
  assign rf_val = rf_val_q;
  assign rf_pc  = rf_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scoreboard bench for wb_port_arbiter (honours WB_ARB_STARVE_EN).
`default_nettype none

module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk, resetn;
  logic        p_valid, p_we, m_valid, m_ready, rf_we, pipe_stall;
  logic [4:0]  p_dst, m_dst, rf_dst;
  logic [31:0] p_val, p_pc, m_val, m_pc, rf_val, rf_pc;
  logic [1:0]  pend_cnt;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] val;
    logic [31:0] pc;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .p_valid(p_valid), .p_we(p_we), .p_dst(p_dst), .p_val(p_val), .p_pc(p_pc),
    .m_valid(m_valid), .m_dst(m_dst), .m_val(m_val), .m_pc(m_pc), .m_ready(m_ready),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_val(rf_val), .rf_pc(rf_pc),
    .pipe_stall(pipe_stall), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] d, input logic [31:0] val, input logic [31:0] pc);
    p_valid = v; p_we = v; p_dst = d; p_val = val; p_pc = pc;
  endtask

  task automatic mreq(input logic v, input logic [4:0] d, input logic [31:0] val, input logic [31:0] pc);
    m_valid = v; m_dst = d; m_val = val; m_pc = pc;
  endtask

  task automatic expect_wr(input logic [4:0] d, input logic [31:0] val, input logic [31:0] pc);
    wr_t w;
    w.dst = d; w.val = val; w.pc = pc;
    sb.push_back(w);
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rf_we === 1'b1) begin
      logic nonempty;
      nonempty = (sb.size() != 0);
      chk("wr_expected", 32'(nonempty), 32'd1);
      if (nonempty) begin
        wr_t w;
        w = sb.pop_front();
        chk("wr_dst", 32'(rf_dst), 32'(w.dst));
        chk("wr_val", rf_val, w.val);
        chk("wr_pc", rf_pc, w.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic exp_stall;
    resetn = 1'b0;
    pipe(0, 0, 0, 0);
    mreq(0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_dst", 32'(rf_dst), 0);
    chk("rst_rf_val", rf_val, 0);
    chk("rst_rf_pc", rf_pc, 0);
    chk("rst_pend", 32'(pend_cnt), 0);
    chk("rst_stall", 32'(pipe_stall), 0);
    resetn = 1'b1;
    tick();
    chk("rst_m_ready", 32'(m_ready), 1);

    // Single buffered result, pipeline idle
    mreq(1, 5, 32'h11, 32'h100);
    expect_wr(5, 32'h11, 32'h100);
    tick();
    mreq(0, 0, 0, 0);
    chk("basic_pend1", 32'(pend_cnt), 1);
    chk("basic_we_early", 32'(rf_we), 0);
    tick();
    chk("basic_we", 32'(rf_we), 1);
    chk("basic_dst", 32'(rf_dst), 5);
    chk("basic_pend0", 32'(pend_cnt), 0);
    tick();
    chk("basic_we_off", 32'(rf_we), 0);
    chk("basic_dst_hold", 32'(rf_dst), 5);

    // Ineligible pipeline requests: p_we low, dst zero
    p_valid = 1; p_we = 0; p_dst = 6; p_val = 32'h66; p_pc = 32'h600;
    tick();
    pipe(1, 0, 32'h77, 32'h700);
    tick();
    pipe(0, 0, 0, 0);
    chk("inelig_we0", 32'(rf_we), 0);
    tick();
    chk("inelig_dst0", 32'(rf_we), 0);

    // Starvation: pipeline busy on r3, buffered r7 waiting
    n = 0;
    for (int i = 0; i <= LIMIT + 3; i++) begin
      exp_stall = STARVE && (i == LIMIT + 1);
      chk("starve_stall", 32'(pipe_stall), 32'(exp_stall));
      if (i == LIMIT + 2) chk("starve_dst", 32'(rf_dst), STARVE ? 32'd7 : 32'd3);
      pipe(1, 3, 32'h300 + n, 32'h3000 + n);
      if (i == 0) mreq(1, 7, 32'h77, 32'h7000);
      else        mreq(0, 0, 0, 0);
      if (!exp_stall) begin
        expect_wr(3, 32'h300 + n, 32'h3000 + n);
        n++;
      end else begin
        expect_wr(7, 32'h77, 32'h7000);
      end
      tick();
    end
    chk("starve_pend_busy", 32'(pend_cnt), STARVE ? 32'd0 : 32'd1);
    pipe(0, 0, 0, 0);
    if (!STARVE) expect_wr(7, 32'h77, 32'h7000);
    repeat (3) tick();
    chk("starve_pend_end", 32'(pend_cnt), 0);

    // Pipeline write to the same dst kills the buffered result
    mreq(1, 9, 32'hA, 32'h900);
    tick();
    mreq(0, 0, 0, 0);
    pipe(1, 9, 32'hB, 32'h990);
    expect_wr(9, 32'hB, 32'h990);
    chk("kill_pend1", 32'(pend_cnt), 1);
    tick();
    pipe(0, 0, 0, 0);
    chk("kill_dead_pend", 32'(pend_cnt), 1);
    chk("kill_val", rf_val, 32'hB);
    tick();
    chk("kill_pend0", 32'(pend_cnt), 0);
    tick();
    chk("kill_no_second", 32'(rf_we), 0);

    // Same-cycle push to the granted dst is not killed
    pipe(1, 4, 32'h40, 32'h400);
    mreq(1, 4, 32'h41, 32'h410);
    expect_wr(4, 32'h40, 32'h400);
    expect_wr(4, 32'h41, 32'h410);
    tick();
    pipe(0, 0, 0, 0);
    mreq(0, 0, 0, 0);
    repeat (2) tick();
    chk("samecyc_pend", 32'(pend_cnt), 0);

    // Fill to DEPTH twice (pointer wrap), refuse pushes while full
    for (int r = 0; r < 2; r++) begin
      pipe(1, 2, 32'h200 + 4 * r, 32'h2000);
      mreq(1, 5'(10 + 2 * r), 32'h1000 + r, 32'h10);
      expect_wr(2, 32'h200 + 4 * r, 32'h2000);
      tick();
      chk("full_ready1", 32'(m_ready), 1);
      chk("full_pend1", 32'(pend_cnt), 1);
      pipe(1, 2, 32'h201 + 4 * r, 32'h2001);
      mreq(1, 5'(11 + 2 * r), 32'h1100 + r, 32'h11);
      expect_wr(2, 32'h201 + 4 * r, 32'h2001);
      tick();
      chk("full_pend2", 32'(pend_cnt), 2);
      chk("full_ready0", 32'(m_ready), 0);
      pipe(1, 2, 32'h202 + 4 * r, 32'h2002);
      mreq(1, 30, 32'hDEAD, 32'hDEAD);
      expect_wr(2, 32'h202 + 4 * r, 32'h2002);
      tick();
      chk("full_ready0_pop", 32'(m_ready), 0);
      chk("full_pend2_hold", 32'(pend_cnt), 2);
      pipe(0, 0, 0, 0);
      expect_wr(5'(10 + 2 * r), 32'h1000 + r, 32'h10);
      expect_wr(5'(11 + 2 * r), 32'h1100 + r, 32'h11);
      tick();
      chk("full_drain1", 32'(pend_cnt), 1);
      mreq(0, 0, 0, 0);
      tick();
      chk("full_drain0", 32'(pend_cnt), 0);
      tick();
    end

    // dst 0 result is dropped without a write
    mreq(1, 0, 32'h55, 32'h500);
    tick();
    mreq(0, 0, 0, 0);
    chk("dst0_pend1", 32'(pend_cnt), 1);
    tick();
    chk("dst0_pend0", 32'(pend_cnt), 0);
    chk("dst0_no_we", 32'(rf_we), 0);

    // Reset with two results pending discards them
    pipe(1, 2, 32'h250, 32'h2500);
    mreq(1, 20, 32'h20, 32'h20);
    expect_wr(2, 32'h250, 32'h2500);
    tick();
    pipe(1, 2, 32'h251, 32'h2501);
    mreq(1, 21, 32'h21, 32'h21);
    expect_wr(2, 32'h251, 32'h2501);
    tick();
    mreq(0, 0, 0, 0);
    chk("rst2_pend2", 32'(pend_cnt), 2);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    pipe(0, 0, 0, 0);
    #1;
    chk("rst2_pend0", 32'(pend_cnt), 0);
    chk("rst2_we0", 32'(rf_we), 0);
    chk("rst2_stall0", 32'(pipe_stall), 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (5) tick();
    chk("rst2_after_we", 32'(rf_we), 0);
    chk("rst2_after_pend", 32'(pend_cnt), 0);
    chk("rst2_after_ready", 32'(m_ready), 1);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
